multi_pulse: RTL

Multi-channel, parametrised successor of the single-channel ms pulse generator. It provides CHANNELS independent pulse generators, each with its own length register and mode. Modes are one-shot, retriggerable one-shot and periodic, and each channel has its own abort input. The block sits between the satellite register/control logic and the output drivers, in the masterClk domain.

---
 rtl/multi_pulse_pkg.sv | 24 ++
 rtl/pulse_channel.sv | 139 +++++++++++++
 rtl/multi_pulse.sv | 38 +++
 3 files changed

// File: rtl/multi_pulse_pkg.sv
// Shared encodings and defaults for the multi-channel pulse generator.
// The tick period falls back to 1000 masterClk cycles per ms when the environment gives none.
`ifndef MASTER_CLK_CYC_PER_MS
`define MASTER_CLK_CYC_PER_MS 1000
`endif

package multi_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_RETRIG   = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_OFF      = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_e;

    localparam int DEFAULT_TICK_CYC = `MASTER_CLK_CYC_PER_MS;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: trigger edge detector, tick prescaler, length counter and
// IDLE/HIGH/LOW state machine with registered outputs.
module pulse_channel
    import multi_pulse_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int TICK_CYC = DEFAULT_TICK_CYC
) (
    input  logic             i_masterClk,
    input  logic             i_reset,
    input  logic [LEN_W-1:0] i_pulseLength,
    input  logic [1:0]       i_mode,
    input  logic             i_trigger,
    input  logic             i_abort,
    output logic             o_pulse,
    output logic             o_pulseInv,
    output logic             o_active
);

    localparam int TICK_W = $clog2(TICK_CYC);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

    state_e            r_state;
    logic              r_prevTrigger;
    logic [TICK_W-1:0] r_tickCnt;
    logic [LEN_W-1:0]  r_lenCnt;
    logic [LEN_W-1:0]  r_lenReg;
    logic              r_pulse;
    logic              r_pulseInv;
    logic              r_active;

    mode_e w_mode;
    logic  w_trigEdge;
    logic  w_lenOk;
    logic  w_wrap;
    logic  w_phaseEnd;

    assign w_mode     = mode_e'(i_mode);
    assign w_trigEdge = i_trigger & ~r_prevTrigger;
    assign w_lenOk    = (i_pulseLength != '0);
    assign w_wrap     = (r_tickCnt == TICK_LAST);
    assign w_phaseEnd = w_wrap && (r_lenCnt == LEN_W'(1));

    // prevTrigger resets high so a trigger held through reset release never fires.
    always_ff @(posedge i_masterClk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_prevTrigger <= 1'b1;
            r_tickCnt     <= '0;
            r_lenCnt      <= '0;
            r_lenReg      <= '0;
            r_pulse       <= 1'b0;
            r_pulseInv    <= 1'b1;
            r_active      <= 1'b0;
        end else begin
            r_prevTrigger <= i_trigger;
            if (i_abort) begin
                r_state    <= ST_IDLE;
                r_pulse    <= 1'b0;
                r_pulseInv <= 1'b1;
                r_active   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_trigEdge && (w_mode != MODE_OFF) && w_lenOk) begin
                            r_lenReg   <= i_pulseLength;
                            r_lenCnt   <= i_pulseLength;
                            r_tickCnt  <= '0;
                            r_state    <= ST_HIGH;
                            r_pulse    <= 1'b1;
                            r_pulseInv <= 1'b0;
                            r_active   <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if ((w_mode == MODE_RETRIG) && w_trigEdge && w_lenOk) begin
                            r_lenReg  <= i_pulseLength;
                            r_lenCnt  <= i_pulseLength;
                            r_tickCnt <= '0;
                        end else begin
                            r_tickCnt <= w_wrap ? '0 : r_tickCnt + 1'b1;
                            if (w_wrap && !w_phaseEnd) begin
                                r_lenCnt <= r_lenCnt - 1'b1;
                            end
                            if (w_phaseEnd) begin
                                if ((w_mode == MODE_PERIODIC) && i_trigger) begin
                                    r_lenCnt   <= r_lenReg;
                                    r_state    <= ST_LOW;
                                    r_pulse    <= 1'b0;
                                    r_pulseInv <= 1'b1;
                                    r_active   <= 1'b1;
                                end else begin
                                    r_lenCnt   <= '0;
                                    r_state    <= ST_IDLE;
                                    r_pulse    <= 1'b0;
                                    r_pulseInv <= 1'b1;
                                    r_active   <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_LOW: begin
                        r_tickCnt <= w_wrap ? '0 : r_tickCnt + 1'b1;
                        if (w_wrap && !w_phaseEnd) begin
                            r_lenCnt <= r_lenCnt - 1'b1;
                        end
                        // The low phase always hands back to HIGH unless the channel was switched off.
                        if (w_phaseEnd) begin
                            if (w_mode == MODE_OFF) begin
                                r_lenCnt   <= '0;
                                r_state    <= ST_IDLE;
                                r_pulse    <= 1'b0;
                                r_pulseInv <= 1'b1;
                                r_active   <= 1'b0;
                            end else begin
                                r_lenCnt   <= r_lenReg;
                                r_state    <= ST_HIGH;
                                r_pulse    <= 1'b1;
                                r_pulseInv <= 1'b0;
                                r_active   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_pulse    <= 1'b0;
                        r_pulseInv <= 1'b1;
                        r_active   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_pulse    = r_pulse;
    assign o_pulseInv = r_pulseInv;
    assign o_active   = r_active;

endmodule

// File: rtl/multi_pulse.sv
// CHANNELS independent pulse generators sharing masterClk and reset;
// each channel takes its own slice of the length, mode, trigger and abort buses.
module multi_pulse
    import multi_pulse_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int LEN_W    = 8,
    parameter int TICK_CYC = DEFAULT_TICK_CYC
) (
    input  logic                      masterClk,
    input  logic                      reset,
    input  logic [CHANNELS*LEN_W-1:0] pulseLength,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [CHANNELS-1:0]       abort,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       pulseInv,
    output logic [CHANNELS-1:0]       active
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        pulse_channel #(
            .LEN_W    (LEN_W),
            .TICK_CYC (TICK_CYC)
        ) u_channel (
            .i_masterClk   (masterClk),
            .i_reset       (reset),
            .i_pulseLength (pulseLength[i*LEN_W +: LEN_W]),
            .i_mode        (mode[2*i +: 2]),
            .i_trigger     (trigger[i]),
            .i_abort       (abort[i]),
            .o_pulse       (pulse[i]),
            .o_pulseInv    (pulseInv[i]),
            .o_active      (active[i])
        );
    end

endmodule
